reg_pipe: RTL and testbench
===========================

Name: reg_pipe

Overview:
- Parametrised, enable-gated register pipeline; generalises the single-bit D flip-flop to WIDTH bits × DEPTH stages.
- Each stage carries a valid tag. A running occupancy count is maintained, and all stage contents are exposed as taps.
- Used as the standard delay/retiming element for datapaths that need an N-cycle latency, stall (enable) and flush (synchronous clear).

Parameters:
- WIDTH, 8, data bits per stage; legal range 1 or more.
- DEPTH, 4, number of register stages (latency in enabled cycles); legal range 1 or more.
- RST_VAL, 0, value loaded into every data stage by rst and by sclr; WIDTH bits wide.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  shift enable; when 0 the pipeline holds (stall).
- sclr  in  1  synchronous clear (flush).
- din  in  WIDTH  data into stage 0.
- vin  in  1  valid tag accompanying din.
- dout  out  WIDTH  data of stage DEPTH-1.
- vout  out  1  valid tag of stage DEPTH-1.
- taps  out  WIDTH*DEPTH  all stage data; stage k occupies bits [k*WIDTH +: WIDTH]; stage 0 is in the LSBs.
- vtaps  out  DEPTH  valid tag of each stage; bit k belongs to stage k.
- occ  out  $clog2(DEPTH+1)  number of stages currently holding a valid tag.
- full  out  1  asserted when occ == DEPTH.
- empty  out  1  asserted when occ == 0.

Behaviour:
- Reset: rst high sets, asynchronously and immediately (no clock required):
  - all data stages to RST_VAL;
  - all valid tags to 0;
  - occ to 0, full to 0, empty to 1.
  - State remains held while rst is high. The first update occurs on the first rising clk edge after rst falls.
- Priority at each rising edge: rst > sclr > en > hold.
- sclr = 1 (regardless of en):
  - all data stages go to RST_VAL;
  - all tags go to 0;
  - occ goes to 0.
  - din and vin on that cycle are discarded.
- en = 1, sclr = 0:
  - stage0 takes din/vin;
  - stage k takes stage k-1 for k = 1..DEPTH-1;
  - the contents of stage DEPTH-1 are dropped.
- en = 0, sclr = 0: every stage holds its value and tag; occ holds.
- Latency: a value presented on din with en = 1 at edge n appears on dout after edge n+DEPTH-1 (visible during the following cycle), provided en = 1 at each of the intervening DEPTH-1 edges. Stalled cycles add one cycle each.
- Data moves regardless of its tag. Invalid slots are real bubbles and are still shifted.
- occ update on an enabled shift:
  - occ_next = occ + vin − vtaps[DEPTH-1].
  - Simultaneous entry and exit leaves occ unchanged.
  - occ is a registered counter, not a combinational popcount. The bench must check occ == popcount(vtaps) on every cycle.
- occ never exceeds DEPTH and never underflows. The bench checks this with an assertion.
- full and empty are combinational decodes of occ.
- DEPTH = 1: reduces to an enabled D flip-flop with async reset plus a tag. occ is 1 bit wide.
- Outputs are driven directly from registers (except full and empty), with no combinational path from din to dout.
- An async rst assertion mid-stream clears everything immediately. Deassertion is synchronous to the design's use; the block itself does not synchronise rst.

Decomposition:
- Shared package `reg_pipe_pkg`:
  - occ-width function clog2;
  - default WIDTH, DEPTH and RST_VAL constants;
  - no typedefs needed.
- Natural sub-module: `reg_stage`, a single WIDTH+1 bit register (data plus tag) with async rst, sclr and en.
  - The top level instantiates DEPTH of these in a generate loop and contains the occ counter plus the full/empty decode.

Test Plan:
1. Reset: with WIDTH = 8, DEPTH = 4, RST_VAL = 8'hA5, assert rst mid-cycle (no clk edge) -> taps = 32'hA5A5A5A5, vtaps = 0, occ = 0, empty = 1, immediately.
2. Streaming: en = 1; vin = 1; din = 8'h01, 02, 03, 04, 05 on successive edges -> dout = 8'h01 with vout = 1 after the 4th edge, 8'h02 after the 5th; occ = 1, 2, 3, 4, then 4 (full = 1 from the 4th edge).
3. Stall: load 8'h11/8'h22 in two enabled cycles, then hold en = 0 for 3 cycles with din changing -> taps and occ unchanged. After en = 1 resumes, 8'h11 reaches dout after two further edges (4 enabled edges in total).
4. Bubbles: vin pattern 1, 0, 1, 1, 0, 0, 0, 0 with en = 1 -> occ = 1, 1, 2, 3, 2, 2, 1, 0. vout pattern reproduces vin delayed 4 edges. occ == popcount(vtaps) on every cycle.
5. Flush vs enable: pipeline full; assert sclr = 1 and en = 1 with vin = 1, din = 8'hFF -> next cycle all stages = RST_VAL, occ = 0, empty = 1, and 8'hFF is not captured.
6. DEPTH = 1 instance: acts as a D flip-flop. din = 1, 0, 1 with en = 1 -> dout follows after one edge. rst = 1 forces dout = RST_VAL asynchronously, matching the async-reset positive-edge D flip-flop.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared constants and helpers for the reg_pipe register pipeline.
//   DEF_WIDTH   - default data bits per stage
//   DEF_DEPTH   - default number of stages
//   DEF_RST_VAL - default reset/clear value of each data stage
//   clog2()     - ceiling log2, used to size the occupancy counter
package reg_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam logic [DEF_WIDTH-1:0] DEF_RST_VAL = '0;

  // Ceiling log2; clog2(DEPTH+1) gives the bits needed to count 0..DEPTH.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_stage.sv
// reg_stage: one pipeline stage, WIDTH data bits plus a valid tag.
//   clk_i   - clock, rising edge
//   rst_i   - asynchronous active-high reset (data <= RST_VAL, tag <= 0)
//   en_i    - load enable; holds when low
//   sclr_i  - synchronous clear, wins over en_i
//   d_i/v_i - data and tag to load
//   q_o/v_o - registered data and tag
module reg_stage
  import reg_pipe_pkg::*;
#(
  parameter int unsigned       WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sclr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             v_i,
  output logic [WIDTH-1:0] q_o,
  output logic             v_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (sclr_i) begin
      data_d = RST_VAL;
      vld_d  = 1'b0;
    end else if (en_i) begin
      data_d = d_i;
      vld_d  = v_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= RST_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q_o = data_q;
  assign v_o = vld_q;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: enable-gated WIDTH x DEPTH register pipeline with valid tags.
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   en    - shift enable (0 = stall)
//   sclr  - synchronous flush, wins over en
//   din   - data into stage 0,  vin - its valid tag
//   dout  - data of last stage, vout - its valid tag
//   taps  - all stage data, stage k at [k*WIDTH +: WIDTH]
//   vtaps - all stage tags, bit k = stage k
//   occ   - registered count of valid stages
//   full  - occ == DEPTH,  empty - occ == 0
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int unsigned       WIDTH   = DEF_WIDTH,
  parameter int unsigned       DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(DEF_RST_VAL),
  localparam int unsigned      OCC_W   = clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sclr,
  input  logic [WIDTH-1:0]       din,
  input  logic                   vin,
  output logic [WIDTH-1:0]       dout,
  output logic                   vout,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       vtaps,
  output logic [OCC_W-1:0]       occ,
  output logic                   full,
  output logic                   empty
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic             stage_v [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;

    if (k == 0) begin : g_head
      assign d_in = din;
      assign v_in = vin;
    end else begin : g_body
      assign d_in = stage_q[k-1];
      assign v_in = stage_v[k-1];
    end

    reg_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (en),
      .sclr_i (sclr),
      .d_i    (d_in),
      .v_i    (v_in),
      .q_o    (stage_q[k]),
      .v_o    (stage_v[k])
    );

    assign taps[k*WIDTH +: WIDTH] = stage_q[k];
    assign vtaps[k]               = stage_v[k];
  end

  assign dout = stage_q[DEPTH-1];
  assign vout = stage_v[DEPTH-1];

  // Occupancy is tracked incrementally: +1 for a valid entry, -1 for a valid
  // tag shifted out of the last stage, so it stays a plain register.
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (sclr) begin
      occ_d = '0;
    end else if (en) begin
      occ_d = occ_q + OCC_W'(vin) - OCC_W'(stage_v[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ   = occ_q;
  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);

endmodule

// File: tb/tb_reg_pipe.sv
module tb_reg_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 / WIDTH=8 instance
  logic        rst, en, sclr, vin;
  logic [7:0]  din, dout;
  logic        vout, full, empty;
  logic [31:0] taps;
  logic [3:0]  vtaps;
  logic [2:0]  occ;

  // DEPTH=1 / WIDTH=1 instance
  logic        rst1, en1, sclr1, vin1;
  logic [0:0]  din1, dout1, taps1, vtaps1, occ1;
  logic        vout1, full1, empty1;

  reg_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sclr(sclr), .din(din), .vin(vin),
    .dout(dout), .vout(vout), .taps(taps), .vtaps(vtaps), .occ(occ),
    .full(full), .empty(empty)
  );

  reg_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_d1 (
    .clk(clk), .rst(rst1), .en(en1), .sclr(sclr1), .din(din1), .vin(vin1),
    .dout(dout1), .vout(vout1), .taps(taps1), .vtaps(vtaps1), .occ(occ1),
    .full(full1), .empty(empty1)
  );

  typedef struct packed {
    logic        sel;    // 0: DEPTH=4 instance, 1: DEPTH=1 instance
    logic [31:0] taps;
    logic [3:0]  vtaps;
    logic [2:0]  occ;
    logic        full;
    logic        empty;
    logic [7:0]  dout;
    logic        vout;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  async_q[$];
  string async_name_q[$];
  event  async_ev;

  int n_tot  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_item(input string nm, input exp_t e);
    if (!e.sel) begin
      chk({nm, ".taps"},  taps,            e.taps);
      chk({nm, ".vtaps"}, 32'(vtaps),      32'(e.vtaps));
      chk({nm, ".occ"},   32'(occ),        32'(e.occ));
      chk({nm, ".full"},  32'(full),       32'(e.full));
      chk({nm, ".empty"}, 32'(empty),      32'(e.empty));
      chk({nm, ".dout"},  32'(dout),       32'(e.dout));
      chk({nm, ".vout"},  32'(vout),       32'(e.vout));
    end else begin
      chk({nm, ".dout1"},  32'(dout1),  32'(e.dout[0]));
      chk({nm, ".taps1"},  32'(taps1),  32'(e.dout[0]));
      chk({nm, ".vout1"},  32'(vout1),  32'(e.vout));
      chk({nm, ".occ1"},   32'(occ1),   32'(e.occ[0]));
      chk({nm, ".full1"},  32'(full1),  32'(e.full));
      chk({nm, ".empty1"}, 32'(empty1), 32'(e.empty));
    end
  endtask

  // Clocked monitor: one expectation per edge at which stimulus was issued.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check_item(name_q.pop_front(), exp_q.pop_front());
  end

  // Asynchronous-reset monitor: fires without any clock edge.
  always @(async_ev) begin
    while (async_q.size() > 0) check_item(async_name_q.pop_front(), async_q.pop_front());
  end

  // Registered occ must always equal the number of set tags.
  always @(negedge clk) begin
    chk("occ_pop",  32'(occ),  32'($countones(vtaps)));
    chk("occ_pop1", 32'(occ1), 32'(vtaps1));
  end

  always @(negedge clk) begin
    assert (occ <= 3'd4) else $error("FAIL occ_range: got %0d expected <= 4", occ);
  end

  // Reference model of the DEPTH=4 pipe contents.
  logic [7:0] md [4];
  logic [3:0] mv;

  task automatic mreset();
    for (int k = 0; k < 4; k++) md[k] = 8'hA5;
    mv = '0;
  endtask

  function automatic exp_t mk_exp(input int eocc);
    exp_t x;
    x       = '0;
    x.sel   = 1'b0;
    x.taps  = {md[3], md[2], md[1], md[0]};
    x.vtaps = mv;
    x.occ   = 3'(eocc);
    x.full  = (eocc == 4);
    x.empty = (eocc == 0);
    x.dout  = md[3];
    x.vout  = mv[3];
    return x;
  endfunction

  // Called at a negedge: drive inputs, record expectation after next edge.
  task automatic step(input logic e, input logic s, input logic [7:0] d,
                      input logic v, input int eocc, input string nm);
    en = e; sclr = s; din = d; vin = v;
    if (s) mreset();
    else if (e) begin
      for (int k = 3; k > 0; k--) md[k] = md[k-1];
      md[0] = d;
      mv    = {mv[2:0], v};
    end
    exp_q.push_back(mk_exp(eocc));
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic step1(input logic e, input logic s, input logic d, input logic v,
                       input logic edout, input logic evout, input string nm);
    exp_t x;
    en1 = e; sclr1 = s; din1 = d; vin1 = v;
    x       = '0;
    x.sel   = 1'b1;
    x.dout  = {7'b0, edout};
    x.vout  = evout;
    x.occ   = {2'b0, evout};
    x.full  = evout;
    x.empty = ~evout;
    exp_q.push_back(x);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  // Raise rst between edges and check the effect before any clock edge.
  task automatic async_rst_main(input string nm);
    #2;
    rst = 1'b1;
    #1;
    mreset();
    async_q.push_back(mk_exp(0));
    async_name_q.push_back(nm);
    -> async_ev;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t x;
    rst = 1'b1; en = 1'b0; sclr = 1'b0; din = '0; vin = 1'b0;
    rst1 = 1'b1; en1 = 1'b0; sclr1 = 1'b0; din1 = '0; vin1 = 1'b0;
    mreset();
    repeat (2) @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;

    // Reset asserted mid-cycle after one value entered
    step(1, 0, 8'h3C, 1, 1, "preload");
    async_rst_main("rst_async");

    // Streaming
    step(1, 0, 8'h01, 1, 1, "stream1");
    step(1, 0, 8'h02, 1, 2, "stream2");
    step(1, 0, 8'h03, 1, 3, "stream3");
    step(1, 0, 8'h04, 1, 4, "stream4");   // dout=01, full
    step(1, 0, 8'h05, 1, 4, "stream5");   // dout=02, in and out together

    // Flush beats enable; FF is discarded
    step(1, 1, 8'hFF, 1, 0, "flush_en");

    // Stall
    step(1, 0, 8'h11, 1, 1, "stall_ld1");
    step(1, 0, 8'h22, 1, 2, "stall_ld2");
    step(0, 0, 8'h33, 1, 2, "stall_h1");
    step(0, 0, 8'h44, 0, 2, "stall_h2");
    step(0, 0, 8'h55, 1, 2, "stall_h3");
    step(1, 0, 8'h66, 0, 2, "stall_r1");
    step(1, 0, 8'h77, 0, 2, "stall_r2");  // dout=11 valid
    step(1, 0, 8'h88, 0, 1, "stall_r3");  // 11 drops out
    step(0, 1, 8'h99, 1, 0, "flush_noen");

    // Bubbles
    step(1, 0, 8'hB0, 1, 1, "bub0");
    step(1, 0, 8'hB1, 0, 1, "bub1");
    step(1, 0, 8'hB2, 1, 2, "bub2");
    step(1, 0, 8'hB3, 1, 3, "bub3");      // vout=1 (B0)
    step(1, 0, 8'hB4, 0, 2, "bub4");      // vout=0 (B1)
    step(1, 0, 8'hB5, 0, 2, "bub5");      // vout=1 (B2)
    step(1, 0, 8'hB6, 0, 1, "bub6");      // vout=1 (B3)
    step(1, 0, 8'hB7, 0, 0, "bub7");

    // Async reset mid-stream
    step(1, 0, 8'hC1, 1, 1, "mid1");
    step(1, 0, 8'hC2, 1, 2, "mid2");
    async_rst_main("rst_mid");
    en = 1'b0;

    // DEPTH=1: enabled D flip-flop with tag
    step1(1, 0, 1'b1, 1'b1, 1'b1, 1'b1, "d1_a");
    step1(1, 0, 1'b0, 1'b1, 1'b0, 1'b1, "d1_b");
    step1(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, "d1_hold");
    step1(1, 0, 1'b1, 1'b0, 1'b1, 1'b0, "d1_c");
    step1(1, 0, 1'b1, 1'b1, 1'b1, 1'b1, "d1_d");
    en1 = 1'b0;
    #2;
    rst1 = 1'b1;
    #1;
    x       = '0;
    x.sel   = 1'b1;
    x.empty = 1'b1;
    async_q.push_back(x);
    async_name_q.push_back("d1_rst");
    -> async_ev;
    @(negedge clk);
    rst1 = 1'b0;

    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
